// File: rtl/arm_fetch_unit_pkg.sv
// rtl/arm_fetch_unit_pkg.sv - shared state encodings and constants for the fetch unit
package arm_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_S = 2'd0,
        DRAIN_S = 2'd1,
        HALT_S  = 2'd2
    } fetch_state_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular prefetch buffer with push, pop, flush and occupancy
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic                     o_valid,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    // A flush wins over everything else in the same cycle.
    assign w_push = i_push && !i_flush;
    assign w_pop  = i_pop && (r_cnt != '0) && !i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PTR_W'(1);
            if (w_pop)  r_rd <= r_rd + PTR_W'(1);
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    assign o_valid = (r_cnt != '0);
    assign o_data  = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_cnt;

endmodule

// File: rtl/arm_fetch_unit.sv
// rtl/arm_fetch_unit.sv - instruction fetch front end: fetch PC, imem handshake, prefetch queue
module arm_fetch_unit
    import arm_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_ack,
    input  logic [INST_W-1:0]          imem_rdata,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       halt_req,
    output logic                       halted,
    output logic                       inst_valid,
    output logic [INST_W-1:0]          inst,
    output logic [ADDR_W-1:0]          inst_pc,
    input  logic                       inst_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nx;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nx;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nx;
    logic                r_req;
    logic                w_req_nx;
    logic                w_push;
    logic                w_ack;
    logic                w_room;
    logic [ADDR_W-1:0]   w_redir_pc;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [INST_W+ADDR_W-1:0] w_head;

    assign w_ack      = imem_ack && r_req;
    assign w_redir_pc = redirect_pc & ~ADDR_W'(3);
    assign w_pc_inc   = r_pc + ADDR_W'(PC_STEP);
    // Room counts the in-flight request so an ack can never land in a full queue.
    assign w_room     = ({1'b0, occupancy} + {{CNT_W{1'b0}}, r_req}) < DEPTH_C;

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_addr_nx  = r_addr;
        w_req_nx   = r_req;
        w_push     = 1'b0;
        case (r_state)
            FETCH_S: begin
                if (w_ack && !redirect_valid) begin
                    w_push  = 1'b1;
                    w_pc_nx = w_pc_inc;
                end
                if (redirect_valid) w_pc_nx = w_redir_pc;
                if (r_req && !w_ack) begin
                    // Request still in flight: keep it stable; a redirect must drain it.
                    if (redirect_valid) w_state_nx = DRAIN_S;
                end else begin
                    w_req_nx = 1'b0;
                    if (halt_req) begin
                        w_state_nx = HALT_S;
                    end else if (redirect_valid || w_room) begin
                        w_req_nx  = 1'b1;
                        w_addr_nx = w_pc_nx;
                    end
                end
            end
            DRAIN_S: begin
                if (redirect_valid) w_pc_nx = w_redir_pc;
                if (w_ack) begin
                    w_req_nx = 1'b0;
                    if (halt_req) begin
                        w_state_nx = HALT_S;
                    end else begin
                        w_state_nx = FETCH_S;
                        w_req_nx   = 1'b1;
                        w_addr_nx  = w_pc_nx;
                    end
                end
            end
            HALT_S: begin
                if (redirect_valid) w_pc_nx = w_redir_pc;
                if (!halt_req) w_state_nx = FETCH_S;
            end
            default: begin
                w_state_nx = FETCH_S;
                w_req_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH_S;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_addr  <= w_addr_nx;
            r_req   <= w_req_nx;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .W     (INST_W + ADDR_W)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({imem_rdata, r_addr}),
        .i_pop   (inst_ready),
        .i_flush (redirect_valid),
        .o_valid (inst_valid),
        .o_data  (w_head),
        .o_count (occupancy)
    );

    assign inst      = w_head[ADDR_W +: INST_W];
    assign inst_pc   = w_head[ADDR_W-1:0];
    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign halted    = (r_state == HALT_S);

endmodule

// File: doc/arm_fetch_unit.md
# arm_fetch_unit

Parametrised instruction-fetch front end for the next-generation ARM core. It replaces the direct `inst_addr <= pc_out` path of the single-cycle core. It owns the fetch PC, issues requests to instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a DEPTH-entry prefetch queue. The queue feeds decode through a valid/ready interface. It supports branch redirect with flush and discard of in-flight responses, plus a clean halt.

## Interface
- ADDR_W, 32, fetch address width
- INST_W, 32, instruction width
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, 0, fetch address after reset
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address, word aligned
- imem_ack  in  1  request accepted, imem_rdata valid this cycle
- imem_rdata  in  INST_W  fetched instruction
- redirect_valid  in  1  PC write (branch/exception), one-cycle pulse
- redirect_pc  in  ADDR_W  new fetch PC; bits [1:0] forced to 0
- halt_req  in  1  level; stop issuing new fetches
- halted  out  1  no request outstanding and issue stopped
- inst_valid  out  1  queue head valid
- inst  out  INST_W  queue head instruction
- inst_pc  out  ADDR_W  PC of queue head
- inst_ready  in  1  decode accepts head
- occupancy  out  $clog2(DEPTH+1)  entries in queue

## Operation
- States: FETCH (may issue), DRAIN (waiting for an ack whose data will be dropped), HALTED.
- Issue condition in FETCH: !halt_req && (occupancy + outstanding) < DEPTH. At most one request is outstanding.
- Handshake: once imem_req rises, imem_req and imem_addr stay stable until the cycle imem_ack=1. Ack with req low is ignored.
- On ack in FETCH: push {imem_rdata, imem_addr}. The fetch PC advances by 4, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0).
- Redirect: the queue is flushed, fetch PC is set to redirect_pc, and `occupancy` is 0 next cycle.
  - If a request is outstanding and not acked that cycle, go to DRAIN. In DRAIN, req stays asserted with the old address; the ack's data is dropped. Then return to FETCH, or to HALTED if halt_req is set.
  - Redirect in the same cycle as an ack: that data is dropped, with no DRAIN.
  - Redirect during DRAIN: only the fetch PC is updated.
- Redirect and pop in the same cycle: the decode handshake completes, and the flush still clears all entries.
- Pop and push in the same cycle while full: allowed, occupancy unchanged. Push into a full queue cannot occur, because the issue condition prevents it.
- Halt:
  - While halt_req=1, no new request issues. The outstanding request completes and its data is pushed.
  - Once none is outstanding, go to HALTED and set halted=1. The queue still drains to decode.
  - halt_req=0 returns to FETCH and resumes at the current fetch PC.
  - Redirect while HALTED updates the PC and flushes the queue; the unit stays HALTED.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, halted=0, occupancy=0, state FETCH, fetch PC=RESET_PC.
- rst asserted mid-transaction discards everything. A late ack after reset is ignored, because req is low.
- First imem_req=1 occurs in the first cycle after rst deasserts.
- Fetch latency: ack in cycle t gives inst_valid=1 with that instruction in cycle t+1. The queue is registered, with no bypass.
- Throughput: imem_req may stay high continuously, and the next address is presented in cycle t+1 after an ack in cycle t. This gives 1 instruction per cycle with a zero-wait memory.
- After a redirect in cycle t, the first request to redirect_pc appears in t+1, or the cycle after the DRAIN ack.
- halted rises the cycle after the last outstanding ack, or the cycle after halt_req if none is outstanding.

## Structure
- Shared defines header: state encodings `FETCH_S`, `DRAIN_S`, `HALT_S`, and `PC_STEP` (4).
- Sub-module `fetch_queue`: a circular buffer of DEPTH×(INST_W+ADDR_W) with push, pop, flush, and occupancy. Pointers are log2(DEPTH) bits and wrap naturally; the count has one extra bit.
- The top level holds the FSM, the fetch PC, the outstanding flag, and the handshake register.

## Test plan
- Reset, zero-wait memory, inst_ready=1: addresses 0,4,8,… issue back-to-back, and inst_pc=0 appears one cycle after the first ack.
- inst_ready=0 with DEPTH=4: exactly 4 acks, then req drops and occupancy=4. Raising ready gives one pop per cycle, and req resumes the cycle after occupancy drops to 3.
- Redirect to 0x100 while a req to 0x8 is pending with a 3-cycle ack delay: DRAIN holds addr 0x8, its data is dropped, the next req is 0x100, and the first inst_pc is 0x100.
- Redirect in the same cycle as an ack, plus a pop: the queue is empty next cycle, no DRAIN occurs, and the next addr is the redirect_pc.
- halt_req with a request outstanding: that data is still queued, halted rises the cycle after the ack, and no req issues. Releasing halt resumes at the next sequential PC.
- RESET_PC=0xFFFFFFF8: fetch addresses are 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
